// File: rtl/reg_file_16x32.sv
// 16-entry register file with an architectural PC in R15 and a link register in R14.
// Two combinational read ports with same-cycle write bypass; a single one-hot-selected write port.
module reg_file_16x32 #(
  parameter int DATA_W  = 32,
  parameter int PC_STEP = 4
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              wr_en,
  input  logic [15:0]       wr_sel,
  input  logic [DATA_W-1:0] wr_data,
  input  logic [3:0]        ra_a,
  input  logic [3:0]        ra_b,
  output logic [DATA_W-1:0] rd_a,
  output logic [DATA_W-1:0] rd_b,
  input  logic              pc_inc,
  input  logic              link,
  output logic [DATA_W-1:0] pc,
  output logic              sel_err
);

  localparam logic [DATA_W-1:0] STEP = DATA_W'(PC_STEP);
  localparam logic [DATA_W-1:0] LINK_OFS = DATA_W'(4);
  localparam logic [DATA_W-1:0] READ_OFS = DATA_W'(8);

  logic [DATA_W-1:0] regs [16];
  logic              sel_onehot;
  logic              wr_valid;
  logic [DATA_W-1:0] r15_plus_link;

  function automatic logic is_onehot(input logic [15:0] v);
    return (v != 16'd0) && ((v & (v - 16'd1)) == 16'd0);
  endfunction

  assign sel_onehot    = is_onehot(wr_sel);
  assign wr_valid      = wr_en && sel_onehot;
  assign r15_plus_link = regs[15] + LINK_OFS;

  // R15 reads see PC+8; R0-R14 forward a same-cycle valid write.
  function automatic logic [DATA_W-1:0] read_port(input logic [3:0] addr);
    logic [DATA_W-1:0] val;
    if (addr == 4'd15)
      val = regs[15] + READ_OFS;
    else if (wr_valid && wr_sel[addr])
      val = wr_data;
    else
      val = regs[addr];
    return val;
  endfunction

  assign rd_a = read_port(ra_a);
  assign rd_b = read_port(ra_b);
  assign pc   = regs[15];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < 16; i++) regs[i] <= '0;
      sel_err <= 1'b0;
    end else begin
      for (int i = 0; i < 14; i++)
        if (wr_valid && wr_sel[i]) regs[i] <= wr_data;

      // Link captures the pre-edge PC, independent of any R15 update this edge.
      if (wr_valid && wr_sel[14])
        regs[14] <= wr_data;
      else if (link)
        regs[14] <= r15_plus_link;

      if (wr_valid && wr_sel[15])
        regs[15] <= {wr_data[DATA_W-1:2], 2'b00};
      else if (pc_inc)
        regs[15] <= regs[15] + STEP;

      if (wr_en && !sel_onehot)
        sel_err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_reg_file_16x32.sv
// Directed bench for reg_file_16x32: a register-array model checked every cycle,
// plus literal expectations for the key scenarios.
module tb_reg_file_16x32;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        wr_en;
  logic [15:0] wr_sel;
  logic [31:0] wr_data;
  logic [3:0]  ra_a, ra_b;
  logic [31:0] rd_a, rd_b, pc;
  logic        pc_inc, link, sel_err;

  int chk_cnt  = 0;
  int pass_cnt = 0;
  bit cmp_en   = 1'b0;

  logic [31:0] m [16];
  bit          merr;

  reg_file_16x32 #(.DATA_W(32), .PC_STEP(4)) dut (
    .clk(clk), .reset_n(reset_n), .wr_en(wr_en), .wr_sel(wr_sel), .wr_data(wr_data),
    .ra_a(ra_a), .ra_b(ra_b), .rd_a(rd_a), .rd_b(rd_b), .pc_inc(pc_inc), .link(link),
    .pc(pc), .sel_err(sel_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    chk_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s actual=%h required=%h t=%0t", name, act, exp, $time);
  endtask

  function automatic int sel_target();
    int idx = -1;
    if (wr_en && $countones(wr_sel) == 1)
      for (int i = 0; i < 16; i++) if (wr_sel[i]) idx = i;
    return idx;
  endfunction

  function automatic logic [31:0] mread(input logic [3:0] a);
    int t = sel_target();
    if (a == 4'd15) return m[15] + 32'd8;
    if (t == int'(a)) return wr_data;
    return m[a];
  endfunction

  always @(negedge reset_n) begin
    for (int i = 0; i < 16; i++) m[i] = 32'd0;
    merr = 1'b0;
  end

  always @(posedge clk) begin
    if (reset_n) begin
      logic [31:0] nxt [16];
      logic [31:0] old_pc;
      int t;
      t = sel_target();
      old_pc = m[15];
      for (int i = 0; i < 16; i++) nxt[i] = m[i];
      if (t >= 0) nxt[t] = (t == 15) ? (wr_data & ~32'd3) : wr_data;
      if (t != 15 && pc_inc) nxt[15] = old_pc + 32'd4;
      if (t != 14 && link) nxt[14] = old_pc + 32'd4;
      if (wr_en && t < 0) merr = 1'b1;
      for (int i = 0; i < 16; i++) m[i] = nxt[i];
    end
  end

  always @(negedge clk) begin
    if (cmp_en) begin
      chk("model_rd_a", rd_a, mread(ra_a));
      chk("model_rd_b", rd_b, mread(ra_b));
      chk("model_pc", pc, m[15]);
      chk("model_sel_err", {31'd0, sel_err}, {31'd0, merr});
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    wr_en = 1'b0; wr_sel = 16'h0; wr_data = 32'h0; pc_inc = 1'b0; link = 1'b0;
  endtask

  task automatic wr(input int n, input logic [31:0] d);
    wr_en = 1'b1; wr_sel = 16'h1 << n; wr_data = d;
  endtask

  task automatic rd_both(input logic [3:0] a, input logic [3:0] b);
    ra_a = a; ra_b = b; #1;
  endtask

  // Extra mixed vectors: {wr_en, wr_sel, wr_data, pc_inc, link}
  typedef struct { logic en; logic [15:0] sel; logic [31:0] d; logic inc; logic lnk; } vec_t;
  vec_t vecs [8] = '{
    '{1'b0, 16'h0003, 32'h1111_1111, 1'b1, 1'b0},
    '{1'b1, 16'h0040, 32'h6666_6666, 1'b1, 1'b1},
    '{1'b1, 16'h4000, 32'h0EEE_EEEE, 1'b0, 1'b1},
    '{1'b1, 16'h8000, 32'h0000_2222, 1'b0, 1'b1},
    '{1'b0, 16'h0000, 32'h0,         1'b1, 1'b1},
    '{1'b1, 16'h0200, 32'h9999_0000, 1'b0, 1'b0},
    '{1'b1, 16'h8000, 32'hFFFF_FFFF, 1'b1, 1'b0},
    '{1'b0, 16'hFFFF, 32'hBAD0_BAD0, 1'b1, 1'b0}
  };

  initial begin
    reset_n = 1'b0; ra_a = 4'd0; ra_b = 4'd0;
    idle();
    #12 reset_n = 1'b1;
    step();
    cmp_en = 1'b1;

    // Post-reset state
    rd_both(4'd0, 4'd15);
    chk("reset_r0", rd_a, 32'd0);
    chk("reset_r15_read", rd_b, 32'd8);
    chk("reset_pc", pc, 32'd0);
    chk("reset_sel_err", {31'd0, sel_err}, 32'd0);

    // PC increment sequence, then write R15 beats pc_inc
    pc_inc = 1'b1;
    chk("pc_seq0", pc, 32'd0);
    step(); chk("pc_seq1", pc, 32'd4);
    step(); chk("pc_seq2", pc, 32'd8);
    step(); chk("pc_seq3", pc, 32'd12);
    wr(15, 32'h0000_1003);
    step(); chk("pc_write_wins", pc, 32'h0000_1000);
    idle();

    // Load every register, then read back through both ports
    for (int n = 0; n < 16; n++) begin
      wr(n, 32'hA5A5_0000 + n);
      step();
    end
    idle();
    for (int n = 0; n < 16; n++) begin
      logic [31:0] e;
      e = (n == 15) ? 32'hA5A5_0014 : 32'hA5A5_0000 + n;
      rd_both(4'(n), 4'(n));
      chk($sformatf("load_a_r%0d", n), rd_a, e);
      chk($sformatf("load_b_r%0d", n), rd_b, e);
    end
    step();

    // Link with a concurrent write elsewhere, then link vs write to R14
    wr(15, 32'h0000_0100); step();
    wr(3, 32'h0000_0033); link = 1'b1; step();
    idle();
    rd_both(4'd14, 4'd3);
    chk("link_r14", rd_a, 32'h0000_0104);
    chk("link_r3", rd_b, 32'h0000_0033);
    wr(14, 32'd7); link = 1'b1; step();
    idle();
    rd_both(4'd14, 4'd14);
    chk("link_write_wins", rd_a, 32'd7);

    // Same-cycle bypass on R5, no bypass on R15
    wr(5, 32'h0000_1234); rd_both(4'd5, 4'd15);
    chk("bypass_r5", rd_a, 32'h0000_1234);
    chk("r15_plus8", rd_b, 32'h0000_0108);
    step();
    idle();

    // Non-one-hot write: no effect, sticky error
    wr_en = 1'b1; wr_sel = 16'h0003; wr_data = 32'hDEAD_BEEF; rd_both(4'd0, 4'd1);
    chk("bad_sel_no_bypass_r0", rd_a, 32'hA5A5_0000);
    step();
    idle();
    rd_both(4'd0, 4'd1);
    chk("bad_sel_r0", rd_a, 32'hA5A5_0000);
    chk("bad_sel_r1", rd_b, 32'hA5A5_0001);
    chk("bad_sel_err", {31'd0, sel_err}, 32'd1);
    wr(2, 32'h0000_0022); step(); idle();
    chk("sel_err_sticky", {31'd0, sel_err}, 32'd1);

    // PC wraps modulo 2^32
    wr(15, 32'hFFFF_FFFC); step();
    idle(); pc_inc = 1'b1; step(); idle();
    chk("pc_wrap", pc, 32'd0);

    for (int i = 0; i < 8; i++) begin
      wr_en = vecs[i].en; wr_sel = vecs[i].sel; wr_data = vecs[i].d;
      pc_inc = vecs[i].inc; link = vecs[i].lnk;
      ra_a = 4'(i + 6); ra_b = 4'(15 - i);
      step();
    end
    idle();
    wr(5, 32'h5555_5555); step(); idle();

    // Asynchronous reset between edges, with a write pending across one edge
    @(posedge clk); #2;
    wr(5, 32'h7777_7777); pc_inc = 1'b1; link = 1'b1;
    reset_n = 1'b0;
    #1;
    ra_a = 4'd5; ra_b = 4'd15; wr_en = 1'b0;
    #0.1;
    chk("async_r5", rd_a, 32'd0);
    chk("async_r15_read", rd_b, 32'd8);
    chk("async_pc", pc, 32'd0);
    chk("async_sel_err", {31'd0, sel_err}, 32'd0);
    wr_en = 1'b1;
    step();
    idle();
    #3 reset_n = 1'b1;
    step();
    rd_both(4'd5, 4'd14);
    chk("after_reset_r5", rd_a, 32'd0);
    chk("after_reset_r14", rd_b, 32'd0);
    chk("after_reset_pc", pc, 32'd0);
    step();

    cmp_en = 1'b0;
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
